kband_mem_arbiter: RTL

- Shares one single-port 4096x128 on-chip RAM between two requesters:
  - the HPS/host Avalon-MM slave interface, which does reads and byte-enabled writes;
  - the KBand affine core's arrow-row write stream, which does sequential full-width writes from a loadable base address.
- Does round-robin arbitration and tracks the 1-cycle RAM read latency to generate h_readdatavalid.
- Keeps the core's auto-incrementing write pointer, beat count and wrap flag.
- Sits between the interconnect/core and the RAM wrapper; drives the RAM's address, byteenable, chipselect, write, writedata and clken pins.

---
 rtl/kband_mem_arbiter_if.sv | 47 ++++
 rtl/kband_mem_arbiter.sv | 65 ++++++
 2 files changed

// File: rtl/kband_mem_arbiter_if.sv
// kband_mem_arbiter_if: host Avalon-MM, core write stream and RAM pins of the arbiter.
interface kband_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int BE_W   = DATA_W / 8
);
    logic [ADDR_W-1:0] h_address;
    logic              h_read;
    logic              h_write;
    logic [BE_W-1:0]   h_byteenable;
    logic [DATA_W-1:0] h_writedata;
    logic              h_waitrequest;
    logic [DATA_W-1:0] h_readdata;
    logic              h_readdatavalid;
    logic              c_start;
    logic [ADDR_W-1:0] c_base;
    logic              c_valid;
    logic [DATA_W-1:0] c_data;
    logic              c_ready;
    logic [ADDR_W:0]   c_count;
    logic              c_wrapped;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_clken;

    modport slave (
        input  h_address, h_read, h_write, h_byteenable, h_writedata,
        output h_waitrequest, h_readdata, h_readdatavalid,
        input  c_start, c_base, c_valid, c_data,
        output c_ready, c_count, c_wrapped,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output h_address, h_read, h_write, h_byteenable, h_writedata,
        input  h_waitrequest, h_readdata, h_readdatavalid,
        output c_start, c_base, c_valid, c_data,
        input  c_ready, c_count, c_wrapped,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/kband_mem_arbiter.sv
// kband_mem_arbiter: round-robin sharing of one single-port RAM between host
// reads/writes and the core's sequential write stream.
module kband_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int BE_W   = DATA_W / 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input logic clk,
    input logic reset,
    kband_mem_arbiter_if.slave bus
);
    typedef enum logic {HOST, CORE} grant_e;

    grant_e            last_grant_q, last_grant_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wrapped_q, wrapped_d;
    logic              hreq, creq, host_grant, core_grant;

    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(DEPTH - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= CORE;
            rd_pend_q    <= 1'b0;
            wptr_q       <= '0;
            count_q      <= '0;
            wrapped_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            wptr_q       <= wptr_d;
            count_q      <= count_d;
            wrapped_q    <= wrapped_d;
        end
    end

    always_comb begin
        hreq       = bus.h_read | bus.h_write;
        creq       = bus.c_valid & ~bus.c_start;
        // On conflict the side that did not win last time goes next
        host_grant = ~reset & hreq & (~creq | (last_grant_q == CORE));
        core_grant = ~reset & creq & (~hreq | (last_grant_q == HOST));
        last_grant_d = host_grant ? HOST : core_grant ? CORE : last_grant_q;
        rd_pend_d    = host_grant & bus.h_read & ~bus.h_write;
        wptr_d    = bus.c_start ? bus.c_base : core_grant ? wptr_q + 1'b1 : wptr_q;
        count_d   = bus.c_start ? '0 : (core_grant && count_q != COUNT_MAX) ? count_q + 1'b1 : count_q;
        wrapped_d = bus.c_start ? 1'b0 : (core_grant && wptr_q == WPTR_LAST) ? 1'b1 : wrapped_q;
        bus.h_waitrequest   = hreq & ~host_grant;
        bus.h_readdatavalid = rd_pend_q;
        bus.h_readdata      = rd_pend_q ? bus.mem_readdata : '0;
        bus.c_ready         = creq & core_grant;
        bus.c_count         = count_q;
        bus.c_wrapped       = wrapped_q;
        bus.mem_chipselect  = host_grant | core_grant;
        bus.mem_write       = host_grant ? bus.h_write : core_grant;
        bus.mem_address     = host_grant ? bus.h_address : core_grant ? wptr_q : '0;
        bus.mem_byteenable  = host_grant ? bus.h_byteenable : core_grant ? {BE_W{1'b1}} : '0;
        bus.mem_writedata   = host_grant ? bus.h_writedata : core_grant ? bus.c_data : '0;
        bus.mem_clken       = 1'b1;
    end
endmodule
